// File: rtl/div_ctrl_if.sv
// Handshake and operand bundle between the EX stage, the divider
// datapath and the division sequencer.
interface div_ctrl_if;
   logic        div_req_i;
   logic        div_signed_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic        flush_i;
   logic        div_start_o;
   logic        div_signed_o;
   logic [31:0] div_opa_o;
   logic [31:0] div_opb_o;
   logic        div_cancel_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;
   logic        stall_req_o;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        div_zero_o;
   logic        timeout_o;

   modport slave (
      input  div_req_i, div_signed_i, opa_i, opb_i, flush_i,
      input  div_result_i, div_ready_i,
      output div_start_o, div_signed_o, div_opa_o, div_opb_o,
      output div_cancel_o, stall_req_o, hilo_we_o, hi_o, lo_o,
      output div_zero_o, timeout_o
   );

   modport master (
      output div_req_i, div_signed_i, opa_i, opb_i, flush_i,
      output div_result_i, div_ready_i,
      input  div_start_o, div_signed_o, div_opa_o, div_opb_o,
      input  div_cancel_o, stall_req_o, hilo_we_o, hi_o, lo_o,
      input  div_zero_o, timeout_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle divide sequencer: latches operands, stalls the pipe,
// writes HI/LO on success, aborts on flush or watchdog expiry.
module div_ctrl #(
   parameter int TIMEOUT_CYC = 40
) (
   input logic       clk,
   input logic       rst,
   div_ctrl_if.slave bus
);
   localparam int WW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;

   state_t        state;
   logic [WW-1:0] wdog;
   logic          cxl_last;
   logic          start;
   logic          sgn;
   logic          cancel;
   logic          we;
   logic          zero;
   logic          tmo;
   logic [31:0]   opa;
   logic [31:0]   opb;
   logic [31:0]   hi;
   logic [31:0]   lo;
   logic          accept;

   assign accept = (state == IDLE) && bus.div_req_i && !bus.flush_i;

   // Sequencer: one state register, every output registered except stall
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wdog     <= '0;
         cxl_last <= 1'b0;
         start    <= 1'b0;
         sgn      <= 1'b0;
         cancel   <= 1'b0;
         we       <= 1'b0;
         zero     <= 1'b0;
         tmo      <= 1'b0;
         opa      <= '0;
         opb      <= '0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  opa   <= bus.opa_i;
                  opb   <= bus.opb_i;
                  sgn   <= bus.div_signed_i;
                  wdog  <= '0;
                  start <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               wdog <= wdog + 1'b1;
               if (bus.flush_i) begin
                  start    <= 1'b0;
                  cancel   <= 1'b1;
                  cxl_last <= 1'b0;
                  state    <= CANCEL;
               end else if (bus.div_ready_i) begin
                  start <= 1'b0;
                  we    <= 1'b1;
                  hi    <= bus.div_result_i[63:32];
                  lo    <= bus.div_result_i[31:0];
                  zero  <= (opb == 32'd0);
                  state <= DONE;
               end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                  start    <= 1'b0;
                  cancel   <= 1'b1;
                  tmo      <= 1'b1;
                  cxl_last <= 1'b0;
                  state    <= CANCEL;
               end
            end
            DONE: begin
               we    <= 1'b0;
               zero  <= 1'b0;
               hi    <= '0;
               lo    <= '0;
               state <= IDLE;
            end
            CANCEL: begin
               tmo <= 1'b0;
               if (cxl_last) begin
                  cancel <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cxl_last <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall_req_o  = !rst && ((state == BUSY) || accept);
   assign bus.div_start_o  = start;
   assign bus.div_signed_o = sgn;
   assign bus.div_opa_o    = opa;
   assign bus.div_opb_o    = opb;
   assign bus.div_cancel_o = cancel;
   assign bus.hilo_we_o    = we;
   assign bus.hi_o         = hi;
   assign bus.lo_o         = lo;
   assign bus.div_zero_o   = zero;
   assign bus.timeout_o    = tmo;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for the divide sequencer: table of divisions plus
// flush, watchdog and mid-busy reset sequences.
module tb_div_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   div_ctrl_if bus ();

   div_ctrl #(.TIMEOUT_CYC(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] opa;
      logic [31:0] opb;
      int          lat;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, ".start"}, 64'(bus.div_start_o), 64'd0);
      chk({nm, ".sgn"}, 64'(bus.div_signed_o), 64'd0);
      chk({nm, ".opa"}, 64'(bus.div_opa_o), 64'd0);
      chk({nm, ".opb"}, 64'(bus.div_opb_o), 64'd0);
      chk({nm, ".cancel"}, 64'(bus.div_cancel_o), 64'd0);
      chk({nm, ".stall"}, 64'(bus.stall_req_o), 64'd0);
      chk({nm, ".we"}, 64'(bus.hilo_we_o), 64'd0);
      chk({nm, ".hi"}, 64'(bus.hi_o), 64'd0);
      chk({nm, ".lo"}, 64'(bus.lo_o), 64'd0);
      chk({nm, ".zero"}, 64'(bus.div_zero_o), 64'd0);
      chk({nm, ".tmo"}, 64'(bus.timeout_o), 64'd0);
   endtask

   // Issue a division from IDLE; leaves the DUT in its first BUSY cycle.
   task automatic issue(input string nm, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b);
      bus.div_req_i    = 1'b1;
      bus.div_signed_i = sgn;
      bus.opa_i        = a;
      bus.opb_i        = b;
      #1;
      chk({nm, ".stall_accept"}, 64'(bus.stall_req_o), 64'd1);
      step();
      bus.opa_i        = 32'hDEAD_BEEF;
      bus.opb_i        = 32'h1234_5678;
      bus.div_signed_i = ~sgn;
   endtask

   task automatic run_vec(input vec_t v);
      issue(v.name, v.sgn, v.opa, v.opb);
      for (int k = 1; k <= v.lat; k++) begin
         chk({v.name, ".busy_start"}, 64'(bus.div_start_o), 64'd1);
         chk({v.name, ".busy_stall"}, 64'(bus.stall_req_o), 64'd1);
         chk({v.name, ".busy_opa"}, 64'(bus.div_opa_o), 64'(v.opa));
         chk({v.name, ".busy_opb"}, 64'(bus.div_opb_o), 64'(v.opb));
         chk({v.name, ".busy_sgn"}, 64'(bus.div_signed_o), 64'(v.sgn));
         chk({v.name, ".busy_we"}, 64'(bus.hilo_we_o), 64'd0);
         if (k == v.lat) begin
            bus.div_ready_i  = 1'b1;
            bus.div_result_i = {v.exp_hi, v.exp_lo};
         end
         step();
         bus.div_ready_i  = 1'b0;
         bus.div_result_i = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      chk({v.name, ".done_we"}, 64'(bus.hilo_we_o), 64'd1);
      chk({v.name, ".done_hi"}, 64'(bus.hi_o), 64'(v.exp_hi));
      chk({v.name, ".done_lo"}, 64'(bus.lo_o), 64'(v.exp_lo));
      chk({v.name, ".done_zero"}, 64'(bus.div_zero_o), 64'(v.exp_zero));
      chk({v.name, ".done_start"}, 64'(bus.div_start_o), 64'd0);
      chk({v.name, ".done_stall"}, 64'(bus.stall_req_o), 64'd0);
      step();
      bus.div_req_i = 1'b0;
      #1;
      chk({v.name, ".post_we"}, 64'(bus.hilo_we_o), 64'd0);
      chk({v.name, ".post_zero"}, 64'(bus.div_zero_o), 64'd0);
      chk({v.name, ".post_stall"}, 64'(bus.stall_req_o), 64'd0);
      chk({v.name, ".post_start"}, 64'(bus.div_start_o), 64'd0);
      step();
      chk({v.name, ".idle_start"}, 64'(bus.div_start_o), 64'd0);
   endtask

   initial begin
      vecs[0] = '{"divu_7_2", 1'b0, 32'd7, 32'd2, 3,
                  32'd1, 32'd3, 1'b0};
      vecs[1] = '{"div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 5,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vecs[2] = '{"divu_5_0", 1'b0, 32'd5, 32'd0, 2,
                  32'd0, 32'd0, 1'b1};
      vecs[3] = '{"divu_100_7", 1'b0, 32'd100, 32'd7, 1,
                  32'd2, 32'd14, 1'b0};
      vecs[4] = '{"divu_9_3", 1'b0, 32'd9, 32'd3, 4,
                  32'd0, 32'd3, 1'b0};

      bus.div_req_i    = 1'b0;
      bus.div_signed_i = 1'b0;
      bus.opa_i        = '0;
      bus.opb_i        = '0;
      bus.flush_i      = 1'b0;
      bus.div_result_i = '0;
      bus.div_ready_i  = 1'b0;

      step();
      step();
      chk_zero("reset");
      rst = 1'b0;
      #1;
      chk_zero("post_reset");

      // Request alongside a flush is dropped
      bus.div_req_i = 1'b1;
      bus.flush_i   = 1'b1;
      #1;
      chk("req_flush.stall", 64'(bus.stall_req_o), 64'd0);
      step();
      bus.div_req_i = 1'b0;
      bus.flush_i   = 1'b0;
      #1;
      chk("req_flush.start", 64'(bus.div_start_o), 64'd0);
      chk("req_flush.stall2", 64'(bus.stall_req_o), 64'd0);

      // Stray ready in IDLE is ignored
      bus.div_ready_i  = 1'b1;
      bus.div_result_i = 64'h1111_1111_2222_2222;
      step();
      bus.div_ready_i = 1'b0;
      #1;
      chk("stray_ready.we", 64'(bus.hilo_we_o), 64'd0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Flush on 10th BUSY cycle, racing a ready pulse
      issue("flush", 1'b0, 32'd1000, 32'd3);
      for (int k = 1; k < 10; k++) step();
      chk("flush.busy_stall", 64'(bus.stall_req_o), 64'd1);
      bus.flush_i      = 1'b1;
      bus.div_ready_i  = 1'b1;
      bus.div_result_i = 64'h0000_0001_0000_014D;
      step();
      bus.flush_i     = 1'b0;
      bus.div_ready_i = 1'b0;
      bus.div_req_i   = 1'b0;
      #1;
      chk("flush.cxl1", 64'(bus.div_cancel_o), 64'd1);
      chk("flush.we1", 64'(bus.hilo_we_o), 64'd0);
      chk("flush.stall1", 64'(bus.stall_req_o), 64'd0);
      chk("flush.start1", 64'(bus.div_start_o), 64'd0);
      chk("flush.tmo1", 64'(bus.timeout_o), 64'd0);
      bus.div_ready_i = 1'b1;
      step();
      bus.div_ready_i = 1'b0;
      chk("flush.cxl2", 64'(bus.div_cancel_o), 64'd1);
      chk("flush.we2", 64'(bus.hilo_we_o), 64'd0);
      step();
      chk("flush.cxl3", 64'(bus.div_cancel_o), 64'd0);
      chk("flush.we3", 64'(bus.hilo_we_o), 64'd0);
      run_vec(vecs[4]);

      // Watchdog: divider never answers
      issue("tmo", 1'b0, 32'd50, 32'd5);
      for (int k = 1; k <= 40; k++) begin
         chk("tmo.busy_stall", 64'(bus.stall_req_o), 64'd1);
         chk("tmo.busy_tmo", 64'(bus.timeout_o), 64'd0);
         step();
      end
      bus.div_req_i = 1'b0;
      #1;
      chk("tmo.pulse", 64'(bus.timeout_o), 64'd1);
      chk("tmo.cxl1", 64'(bus.div_cancel_o), 64'd1);
      chk("tmo.stall", 64'(bus.stall_req_o), 64'd0);
      chk("tmo.we", 64'(bus.hilo_we_o), 64'd0);
      step();
      chk("tmo.pulse_end", 64'(bus.timeout_o), 64'd0);
      chk("tmo.cxl2", 64'(bus.div_cancel_o), 64'd1);
      step();
      chk("tmo.cxl3", 64'(bus.div_cancel_o), 64'd0);
      chk("tmo.idle_stall", 64'(bus.stall_req_o), 64'd0);

      // Reset on 5th BUSY cycle
      issue("rst", 1'b1, 32'd77, 32'd7);
      for (int k = 1; k < 5; k++) step();
      chk("rst.busy_start", 64'(bus.div_start_o), 64'd1);
      rst = 1'b1;
      bus.div_req_i = 1'b0;
      step();
      chk_zero("rst_mid");
      rst = 1'b0;
      bus.div_ready_i  = 1'b1;
      bus.div_result_i = 64'h0000_0000_0000_000B;
      step();
      bus.div_ready_i = 1'b0;
      chk("rst.ready_we1", 64'(bus.hilo_we_o), 64'd0);
      step();
      chk("rst.ready_we2", 64'(bus.hilo_we_o), 64'd0);
      chk("rst.ready_lo", 64'(bus.lo_o), 64'd0);

      // Request in first cycle after reset: only stall rises
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.div_req_i = 1'b1;
      bus.opa_i     = 32'd8;
      bus.opb_i     = 32'd2;
      #1;
      chk("rst_req.stall", 64'(bus.stall_req_o), 64'd1);
      chk("rst_req.start", 64'(bus.div_start_o), 64'd0);
      chk("rst_req.we", 64'(bus.hilo_we_o), 64'd0);
      chk("rst_req.cxl", 64'(bus.div_cancel_o), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
